// File: rtl/instrumented_adder_meter.sv
// WIDTH-bit adder wrapped by an IDLE/RUN/DONE controller. It runs either a single
// add (EXT) or iterated accumulate-feedback (RING), counting carry-outs.
module instrumented_adder_meter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [CNT_W-1:0] cycles_in,
  input  logic [WIDTH-1:0] a_inv_mask,
  input  logic [WIDTH-1:0] s_inv_mask,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic [CNT_W-1:0] carry_count,
  output logic [CNT_W-1:0] cycles_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc, b_reg, s_mask_reg;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH:0]   add_res;
  logic             zero_len;

  assign add_res  = {1'b0, acc} + {1'b0, b_reg};
  assign zero_len = mode && (cycles_in == '0);

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc         <= '0;
      b_reg       <= '0;
      s_mask_reg  <= '0;
      remaining   <= '0;
      sum_out     <= '0;
      carry_count <= '0;
      cycles_done <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc         <= a_in ^ a_inv_mask;
            b_reg       <= b_in;
            s_mask_reg  <= s_inv_mask;
            carry_count <= '0;
            cycles_done <= '0;
            remaining   <= mode ? cycles_in : CNT_ONE;
            // A zero-length run skips RUN, so its result is captured right here.
            if (zero_len)
              sum_out <= (a_in ^ a_inv_mask) ^ s_inv_mask;
          end
        end
        RUN: begin
          acc <= add_res[WIDTH-1:0];
          if (add_res[WIDTH] && (carry_count != '1))
            carry_count <= carry_count + CNT_ONE;
          cycles_done <= cycles_done + CNT_ONE;
          remaining   <= remaining - CNT_ONE;
          if (remaining == CNT_ONE)
            sum_out <= add_res[WIDTH-1:0] ^ s_mask_reg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = zero_len ? DONE : RUN;
      RUN:     if (remaining == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_instrumented_adder_meter.sv
// Directed bench for instrumented_adder_meter: a reference model's expected results
// are queued at start and compared when done rises.
module tb_instrumented_adder_meter;

  localparam int unsigned W = 32;
  localparam int unsigned C = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic [C-1:0] carry;
    logic [C-1:0] cyc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, start, mode;
  logic [W-1:0] a_in, b_in, a_inv_mask, s_inv_mask;
  logic [C-1:0] cycles_in;
  logic         busy, done;
  logic [W-1:0] sum_out;
  logic [C-1:0] carry_count, cycles_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  exp_t sb[$];

  instrumented_adder_meter #(.WIDTH(W), .CNT_W(C)) dut (
    .wb_clk_i(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .a_in(a_in), .b_in(b_in), .cycles_in(cycles_in),
    .a_inv_mask(a_inv_mask), .s_inv_mask(s_inv_mask),
    .busy(busy), .done(done), .sum_out(sum_out),
    .carry_count(carry_count), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [C-1:0] cyc, input logic [W-1:0] am,
                                 input logic [W-1:0] sm);
    exp_t e;
    logic [W-1:0] acc;
    logic [W:0]   s;
    int n;
    acc = a ^ am;
    n = md ? int'(cyc) : 1;
    e.carry = '0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, acc} + {1'b0, b};
      acc = s[W-1:0];
      if (s[W] && e.carry != {C{1'b1}}) e.carry = e.carry + 1'b1;
    end
    e.sum = acc ^ sm;
    e.cyc = C'(n);
    e.lat = n;
    return e;
  endfunction

  // Starts a run at the current negedge; poke_at >= 0 re-pulses start with junk inputs
  // at that many cycles after the start edge.
  task automatic run(input string tag, input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [C-1:0] cyc, input logic [W-1:0] am, input logic [W-1:0] sm,
                     input int poke_at);
    exp_t e;
    int lat;
    mode = md; a_in = a; b_in = b; cycles_in = cyc; a_inv_mask = am; s_inv_mask = sm;
    start = 1'b1;
    sb.push_back(model(md, a, b, cyc, am, sm));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 400) begin
      if (lat == poke_at) begin
        start = 1'b1; mode = ~md; a_in = ~a; b_in = b + 32'd3; cycles_in = 16'd1;
        a_inv_mask = ~am; s_inv_mask = ~sm;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_timeout"}, 64'(done), 64'(1));
    check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    check({tag, "_sum"}, 64'(sum_out), 64'(e.sum));
    check({tag, "_carry"}, 64'(carry_count), 64'(e.carry));
    check({tag, "_cycles"}, 64'(cycles_done), 64'(e.cyc));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(1));
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 64'(done), 64'(0));
    check({tag, "_idle_after"}, 64'(busy), 64'(0));
    check({tag, "_sum_hold"}, 64'(sum_out), 64'(e.sum));
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a_in = '0; b_in = '0; cycles_in = '0;
    a_inv_mask = '0; s_inv_mask = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum_out), 64'(0));
    check("rst_carry", 64'(carry_count), 64'(0));
    check("rst_cycles", 64'(cycles_done), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run("ext_5p7", 1'b0, 32'd5, 32'd7, 16'd0, '0, '0, -1);
    run("ext_masks", 1'b0, 32'd0, 32'd1, 16'd0, 32'hFFFF_FFFF, 32'h0000_000F, -1);
    run("ring_8", 1'b1, 32'd0, 32'h4000_0000, 16'd8, '0, '0, -1);
    run("ring_zero", 1'b1, 32'h1234, 32'd99, 16'd0, '0, '0, -1);

    d0 = done_cnt;
    run("ring_poke", 1'b1, 32'h0F0F_0000, 32'h3333_3333, 16'd10, 32'h5, 32'hA0, 3);
    repeat (4) @(negedge clk);
    check("ring_poke_one_done", 64'(done_cnt - d0), 64'(1));
    check("ring_poke_no_restart", 64'(busy), 64'(0));

    // Mid-run reset
    d0 = done_cnt;
    mode = 1'b1; a_in = 32'h1; b_in = 32'hF000_0001; cycles_in = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_sum", 64'(sum_out), 64'(0));
    check("abort_carry", 64'(carry_count), 64'(0));
    check("abort_cycles", 64'(cycles_done), 64'(0));
    repeat (110) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));
    run("after_abort", 1'b0, 32'd5, 32'd7, 16'd0, '0, '0, -1);

    for (int i = 0; i < 6; i++) begin
      logic         m;
      logic [C-1:0] n;
      m = 1'($urandom_range(0, 1));
      n = C'($urandom_range(0, 24));
      run($sformatf("rand%0d", i), m, $urandom, $urandom, n, $urandom, $urandom, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
